// File: rtl/gray_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_cnt_pkg
// Description : Shared definitions for the Gray-code counter: default code
//               width, the control state enumeration and a binary-to-Gray
//               encode function.
// Contents    : GRAY_CNT_WIDTH     - default counter / code width
//               GRAY_CNT_MAX_WIDTH - widest code the encode function handles
//               gray_cnt_state_e   - IDLE / RUN / STALL / DONE
//               gray_enc()         - binary to Gray, g = b ^ (b >> 1)
// Revision    : 1.0 - initial release
// ============================================================================
package gray_cnt_pkg;

    localparam int GRAY_CNT_WIDTH     = 8;
    localparam int GRAY_CNT_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_DONE  = 2'd3
    } gray_cnt_state_e;

    // Works on the widest supported code; narrower callers zero-extend the
    // operand, which leaves the low bits of the result unchanged.
    function automatic logic [GRAY_CNT_MAX_WIDTH-1:0] gray_enc(
        input logic [GRAY_CNT_MAX_WIDTH-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_cnt_bin_gr.sv
`default_nettype none
// ============================================================================
// Module      : bin_gr
// Description : Purely combinational binary-to-Gray converter. It is the exact
//               inverse of the downstream Gray-to-binary stage (gr_bin).
// Ports       : bin_i  [WIDTH-1:0] in  - binary value
//               gray_o [WIDTH-1:0] out - Gray code of bin_i
// Revision    : 1.0 - initial release
// ============================================================================
module bin_gr
    import gray_cnt_pkg::*;
#(
    parameter int WIDTH = GRAY_CNT_WIDTH
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    logic [GRAY_CNT_MAX_WIDTH-1:0] w_bin_ext;
    logic [GRAY_CNT_MAX_WIDTH-1:0] w_gray_ext;

    // Zero extension keeps the MSB of the code equal to the MSB of bin_i,
    // so truncating back to WIDTH yields the correct narrow Gray code.
    assign w_bin_ext  = GRAY_CNT_MAX_WIDTH'(bin_i);
    assign w_gray_ext = gray_enc(w_bin_ext);
    assign gray_o     = w_gray_ext[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/gray_cnt.sv
`default_nettype none
// ============================================================================
// Module      : gray_cnt
// Description : Up/down binary counter with registered Gray-code output,
//               valid/ready handshake toward a Gray-to-binary consumer,
//               wrap or saturate terminal behaviour, parallel load and a
//               one-cycle terminal-count pulse.
// Ports       : clk        in  - clock, rising edge active
//               rst        in  - synchronous active-high reset
//               en         in  - request to advance the count by one
//               up         in  - 1 = increment, 0 = decrement
//               sat        in  - 1 = saturate at terminal, 0 = wrap
//               load       in  - load din into the counter
//               din        in  - binary load value [WIDTH-1:0]
//               dout       out - registered Gray code of the count
//               dout_valid out - dout holds an unconsumed value
//               dout_ready in  - consumer accepts dout this cycle
//               tc         out - one-cycle terminal-count pulse
//               done       out - saturated and halted
// Revision    : 1.0 - initial release
// ============================================================================
module gray_cnt
    import gray_cnt_pkg::*;
#(
    parameter int WIDTH = GRAY_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] C_ZERO     = '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    gray_cnt_state_e   state_q, state_d;
    logic [WIDTH-1:0]  bin_q,   bin_d;
    logic [WIDTH-1:0]  dout_q;
    logic              valid_q, valid_d;
    logic              tc_q,    tc_d;
    logic              done_q,  done_d;

    // ------------------------------------------------------------------
    // Step qualification and candidate next count
    // ------------------------------------------------------------------
    logic              w_step;
    logic [WIDTH-1:0]  w_bin_step;
    logic              w_at_wrap;
    logic [WIDTH-1:0]  w_sat_target;
    logic [WIDTH-1:0]  w_gray_d;

    // A step needs the output slot to be free or being emptied this cycle.
    assign w_step = en && !load && (state_q != ST_DONE) &&
                    (!valid_q || dout_ready);

    // Modular increment / decrement; wrapping falls out of the arithmetic.
    assign w_bin_step   = up ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));

    // True when the current count sits on the terminal for this direction,
    // i.e. the modular step would wrap around.
    assign w_at_wrap    = up ? (bin_q == C_ALL_ONES) : (bin_q == C_ZERO);
    assign w_sat_target = up ? C_ALL_ONES : C_ZERO;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        valid_d = valid_q;
        tc_d    = 1'b0;
        done_d  = done_q;

        if (load) begin
            // Load wins over stepping and backpressure; any unconsumed
            // value is simply replaced.
            bin_d   = din;
            valid_d = 1'b1;
            done_d  = 1'b0;
            state_d = ST_RUN;
        end else if (w_step) begin
            valid_d = 1'b1;
            state_d = ST_RUN;
            if (sat) begin
                // Already on the terminal: hold the count but still report
                // the terminal and halt, rather than wrapping.
                if (!w_at_wrap) begin
                    bin_d = w_bin_step;
                end
                if (w_at_wrap || (w_bin_step == w_sat_target)) begin
                    tc_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end else begin
                bin_d = w_bin_step;
                tc_d  = w_at_wrap;
            end
        end else begin
            if (valid_q && dout_ready) begin
                valid_d = 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (valid_q && !dout_ready) begin
                        state_d = ST_STALL;
                    end else if (!en && !valid_d) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STALL: begin
                    if (dout_ready) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // The Gray code is formed from the next binary count so that dout is a
    // plain register aligned with bin.
    bin_gr #(
        .WIDTH (WIDTH)
    ) u_bin_gr (
        .bin_i  (bin_d),
        .gray_o (w_gray_d)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            dout_q  <= w_gray_d;
            valid_q <= valid_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign tc         = tc_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_cnt
// Description : Self-checking bench for gray_cnt (WIDTH = 8). A behavioural
//               model tracks the count as an integer and derives the
//               expected outputs every cycle; directed scenarios add fixed
//               expected codes, followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_cnt;

    localparam int          W    = 8;
    localparam int unsigned MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         sat = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic         tc;
    logic         done;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int unsigned m_bin   = 0;
    bit          m_valid = 1'b0;
    bit          m_tc    = 1'b0;
    bit          m_done  = 1'b0;

    gray_cnt #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up         (up),
        .sat        (sat),
        .load       (load),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .tc         (tc),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic int unsigned gray_of(input int unsigned b);
        return b ^ (b >> 1);
    endfunction

    // Downstream Gray-to-binary: each binary bit is the XOR of all code
    // bits at and above it.
    function automatic int unsigned gray_to_bin(input logic [W-1:0] g);
        int unsigned acc = 0;
        int unsigned res = 0;
        for (int i = W - 1; i >= 0; i--) begin
            acc = acc ^ int'(g[i]);
            res = res | (acc << i);
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then check every output.
    task automatic tick(input bit r, input bit e, input bit u, input bit s,
                        input bit l, input int unsigned d, input bit rd);
        bit          stp;
        int unsigned tgt;
        @(negedge clk);
        rst = r; en = e; up = u; sat = s; load = l; dout_ready = rd;
        din = W'(d);
        stp = e && !l && !m_done && (!m_valid || rd);
        if (r) begin
            m_bin = 0; m_valid = 0; m_tc = 0; m_done = 0;
        end else if (l) begin
            m_bin = d & MAXV; m_valid = 1; m_tc = 0; m_done = 0;
        end else if (stp) begin
            m_valid = 1;
            m_tc    = 0;
            if (s) begin
                tgt = u ? MAXV : 0;
                if (m_bin != tgt) m_bin = u ? m_bin + 1 : m_bin - 1;
                if (m_bin == tgt) begin
                    m_tc = 1; m_done = 1;
                end
            end else if (u) begin
                m_tc  = (m_bin == MAXV);
                m_bin = (m_bin + 1) % (MAXV + 1);
            end else begin
                m_tc  = (m_bin == 0);
                m_bin = (m_bin + MAXV) % (MAXV + 1);
            end
        end else begin
            m_tc = 0;
            if (m_valid && rd) m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("dout", 32'(dout), gray_of(m_bin));
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        chk("tc", 32'(tc), 32'(m_tc));
        chk("done", 32'(done), 32'(m_done));
        if (m_valid) chk("gr_bin", gray_to_bin(dout), m_bin);
    endtask

    initial begin
        // Reset for two cycles
        tick(1, 0, 1, 0, 0, 0, 0);
        tick(1, 1, 1, 0, 1, 8'h33, 1);
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_valid", 32'(dout_valid), 0);

        // Count up from 5
        tick(0, 0, 1, 0, 1, 5, 1);
        chk("up_load", 32'(dout), 32'h07);
        tick(0, 1, 1, 0, 0, 0, 1);
        chk("up_bin6", 32'(dout), 32'h05);
        tick(0, 1, 1, 0, 0, 0, 1);
        chk("up_bin7", 32'(dout), 32'h04);
        tick(0, 0, 1, 0, 0, 0, 1);
        chk("up_drain", 32'(dout_valid), 0);

        // Wrap up through all-ones
        tick(0, 0, 1, 0, 1, 8'hFE, 1);
        chk("wrap_load", 32'(dout), 32'h81);
        tick(0, 1, 1, 0, 0, 0, 1);
        chk("wrap_ff", 32'(dout), 32'h80);
        chk("wrap_ff_tc", 32'(tc), 0);
        tick(0, 1, 1, 0, 0, 0, 1);
        chk("wrap_00", 32'(dout), 32'h00);
        chk("wrap_00_tc", 32'(tc), 1);
        tick(0, 1, 1, 0, 0, 0, 1);
        chk("wrap_tc_pulse", 32'(tc), 0);
        // Wrap down through zero
        tick(0, 0, 0, 0, 1, 0, 1);
        tick(0, 1, 0, 0, 0, 0, 1);
        chk("wrapdn_ff", 32'(dout), 32'h80);
        chk("wrapdn_tc", 32'(tc), 1);

        // Saturate down to zero
        tick(0, 0, 0, 1, 1, 2, 1);
        tick(0, 1, 0, 1, 0, 0, 1);
        chk("sat_01", 32'(dout), 32'h01);
        tick(0, 1, 0, 1, 0, 0, 1);
        chk("sat_00", 32'(dout), 32'h00);
        chk("sat_tc", 32'(tc), 1);
        chk("sat_done", 32'(done), 1);
        tick(0, 1, 0, 1, 0, 0, 1);
        tick(0, 1, 1, 0, 0, 0, 1);
        chk("sat_hold", 32'(dout), 32'h00);
        chk("sat_hold_done", 32'(done), 1);
        tick(0, 0, 1, 0, 1, 8'h10, 1);
        chk("sat_reload", 32'(dout), 32'h18);
        chk("sat_reload_done", 32'(done), 0);
        // Saturate up, loaded right on the terminal
        tick(0, 0, 1, 1, 1, 8'hFF, 1);
        tick(0, 1, 1, 1, 0, 0, 1);
        chk("satup_hold", 32'(dout), 32'h80);
        chk("satup_done", 32'(done), 1);

        // Backpressure
        tick(0, 0, 1, 0, 1, 8'h20, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 1, 0, 0, 0, 0);
            chk("bp_frozen", 32'(dout), 32'h30);
        end
        tick(0, 1, 1, 0, 0, 0, 1);
        chk("bp_resume", 32'(dout), 32'(gray_of(8'h21)));
        // Load while consumer accepts the old value
        tick(0, 1, 1, 0, 1, 8'h40, 1);
        chk("ld_rdy", 32'(dout), 32'h60);

        // Reset during a stall with dout = 0x05
        tick(0, 0, 1, 0, 1, 6, 0);
        tick(0, 1, 1, 0, 0, 0, 0);
        chk("stall_05", 32'(dout), 32'h05);
        tick(1, 1, 1, 0, 0, 0, 0);
        chk("mid_rst_dout", 32'(dout), 0);
        chk("mid_rst_valid", 32'(dout_valid), 0);
        tick(0, 1, 1, 0, 0, 0, 1);
        chk("rst_first_up", 32'(dout), 32'h01);
        tick(1, 0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 0, 1);
        chk("rst_first_dn", 32'(dout), 32'h80);

        // Randomized run
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 70),
                 1'($urandom),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 8),
                 (($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 32'h0 : MAXV)
                                               : ($urandom & MAXV)),
                 ($urandom_range(0, 99) < 70));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
